// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register scoreboard for the dual-issue pipeline. Every architectural
// register (except x0) owns two small saturating counters:
//   wr_cnt[i] - writers issued to register i that have not yet written back
//   ld_cnt[i] - the subset of those writers that are loads
// Issue slots increment the counters and writeback ports decrement them.
// Issue logic reads the "counter is non-zero" views as bit vectors.
//
// Parameters:
//   CNT_W            width of each per-register counter (max 2^CNT_W-1)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (clears counters and flags)
//   flush            clears all counters next edge; this cycle's events ignored
//   iss0_valid/rd/is_load   issue slot 0 register writer
//   iss1_valid/rd/is_load   issue slot 1 register writer
//   wb0_valid/rd/is_load    writeback port 0 retiring writer
//   wb1_valid/rd/is_load    writeback port 1 retiring writer
//   busy_vec         bit i set while wr_cnt[i] != 0 (bit 0 always 0)
//   load_pending_vec bit i set while ld_cnt[i] != 0 (bit 0 always 0)
//   overflow_err     sticky, a counter tried to exceed its maximum
//   underflow_err    sticky, a decrement found a counter at zero
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        iss0_valid,
    input  logic [4:0]  iss0_rd,
    input  logic        iss0_is_load,
    input  logic        iss1_valid,
    input  logic [4:0]  iss1_rd,
    input  logic        iss1_is_load,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rd,
    input  logic        wb0_is_load,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rd,
    input  logic        wb1_is_load,
    output logic [31:0] busy_vec,
    output logic [31:0] load_pending_vec,
    output logic        overflow_err,
    output logic        underflow_err
);

    // Net update is done two bits wider than the counter: one bit of headroom
    // for +2 and a sign bit so that a -2 result is still distinguishable.
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] wr_cnt  [1:31];
    logic [CNT_W-1:0] ld_cnt  [1:31];
    logic [CNT_W-1:0] wr_next [1:31];
    logic [CNT_W-1:0] ld_next [1:31];
    logic             ovf_any;
    logic             unf_any;

    function automatic logic signed [SUM_W-1:0] widen(input logic b);
        widen = $signed({{(SUM_W-1){1'b0}}, b});
    endfunction

    // cur + inc - dec with saturation at both ends; reports which end clipped.
    function automatic logic [CNT_W-1:0] net_update(
        input  logic [CNT_W-1:0] cur,
        input  logic             inc_a,
        input  logic             inc_b,
        input  logic             dec_a,
        input  logic             dec_b,
        output logic             ovf,
        output logic             unf
    );
        logic signed [SUM_W-1:0] sum;
        logic [CNT_W-1:0]        res;
        sum = $signed({2'b00, cur}) + widen(inc_a) + widen(inc_b)
              - widen(dec_a) - widen(dec_b);
        ovf = 1'b0;
        unf = 1'b0;
        res = sum[CNT_W-1:0];
        if (sum[SUM_W-1]) begin
            unf = 1'b1;
            res = '0;
        end else if (sum > MAX_S) begin
            ovf = 1'b1;
            res = '1;
        end
        return res;
    endfunction

    // Next-state computation for every register. The loop starts at 1, so
    // events targeting x0 never match and are dropped naturally. Loads count
    // against both counters; non-load events only touch wr_cnt.
    always_comb begin
        logic i0, i1, w0, w1;
        logic w_o, w_u, l_o, l_u;
        ovf_any = 1'b0;
        unf_any = 1'b0;
        for (int i = 1; i < 32; i++) begin
            i0 = iss0_valid && (iss0_rd == 5'(i));
            i1 = iss1_valid && (iss1_rd == 5'(i));
            w0 = wb0_valid  && (wb0_rd  == 5'(i));
            w1 = wb1_valid  && (wb1_rd  == 5'(i));
            wr_next[i] = net_update(wr_cnt[i], i0, i1, w0, w1, w_o, w_u);
            ld_next[i] = net_update(ld_cnt[i],
                                    i0 && iss0_is_load, i1 && iss1_is_load,
                                    w0 && wb0_is_load,  w1 && wb1_is_load,
                                    l_o, l_u);
            ovf_any = ovf_any | w_o | l_o;
            unf_any = unf_any | w_u | l_u;
        end
    end

    // Counter and sticky flag registers. Reset beats flush, flush beats the
    // normal update. Flush drops the cycle's events entirely, so it can
    // never raise an error flag, but it also leaves existing flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                wr_cnt[i] <= '0;
                ld_cnt[i] <= '0;
            end
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < 32; i++) begin
                wr_cnt[i] <= '0;
                ld_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                wr_cnt[i] <= wr_next[i];
                ld_cnt[i] <= ld_next[i];
            end
            overflow_err  <= overflow_err  | ovf_any;
            underflow_err <= underflow_err | unf_any;
        end
    end

    // Output views come purely from registered counters, so there is no
    // combinational path from any input to the vectors.
    always_comb begin
        busy_vec         = '0;
        load_pending_vec = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i]         = |wr_cnt[i];
            load_pending_vec[i] = |ld_cnt[i];
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed scenarios followed by a randomized phase. A behavioural model
// keeps plain integer counts per register and predicts the vectors and
// sticky flags after every clock edge.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int CNT_W   = 2;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        iss0_valid, iss0_is_load;
    logic [4:0]  iss0_rd;
    logic        iss1_valid, iss1_is_load;
    logic [4:0]  iss1_rd;
    logic        wb0_valid, wb0_is_load;
    logic [4:0]  wb0_rd;
    logic        wb1_valid, wb1_is_load;
    logic [4:0]  wb1_rd;
    logic [31:0] busy_vec;
    logic [31:0] load_pending_vec;
    logic        overflow_err;
    logic        underflow_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: outstanding counts per register, sticky flags.
    int wr_m [32];
    int ld_m [32];
    bit ovf_m;
    bit unf_m;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .iss0_valid       (iss0_valid),
        .iss0_rd          (iss0_rd),
        .iss0_is_load     (iss0_is_load),
        .iss1_valid       (iss1_valid),
        .iss1_rd          (iss1_rd),
        .iss1_is_load     (iss1_is_load),
        .wb0_valid        (wb0_valid),
        .wb0_rd           (wb0_rd),
        .wb0_is_load      (wb0_is_load),
        .wb1_valid        (wb1_valid),
        .wb1_rd           (wb1_rd),
        .wb1_is_load      (wb1_is_load),
        .busy_vec         (busy_vec),
        .load_pending_vec (load_pending_vec),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic setIdle();
        rst = 1'b0; flush = 1'b0;
        iss0_valid = 1'b0; iss0_rd = '0; iss0_is_load = 1'b0;
        iss1_valid = 1'b0; iss1_rd = '0; iss1_is_load = 1'b0;
        wb0_valid  = 1'b0; wb0_rd  = '0; wb0_is_load  = 1'b0;
        wb1_valid  = 1'b0; wb1_rd  = '0; wb1_is_load  = 1'b0;
    endtask

    task automatic doIssue(input int slot, input int rd, input bit ld);
        if (slot == 0) begin
            iss0_valid = 1'b1; iss0_rd = 5'(rd); iss0_is_load = ld;
        end else begin
            iss1_valid = 1'b1; iss1_rd = 5'(rd); iss1_is_load = ld;
        end
    endtask

    task automatic doWb(input int port, input int rd, input bit ld);
        if (port == 0) begin
            wb0_valid = 1'b1; wb0_rd = 5'(rd); wb0_is_load = ld;
        end else begin
            wb1_valid = 1'b1; wb1_rd = 5'(rd); wb1_is_load = ld;
        end
    endtask

    // Applies one counter update with saturation, reporting clipping.
    function automatic int clipCount(input int n, inout bit ovf, inout bit unf);
        if (n > MAX_CNT) begin
            ovf = 1'b1;
            return MAX_CNT;
        end
        if (n < 0) begin
            unf = 1'b1;
            return 0;
        end
        return n;
    endfunction

    // Advances the model by one edge using the inputs currently driven.
    task automatic modelStep();
        int net_w [32];
        int net_l [32];
        if (rst) begin
            foreach (wr_m[i]) begin wr_m[i] = 0; ld_m[i] = 0; end
            ovf_m = 1'b0;
            unf_m = 1'b0;
            return;
        end
        if (flush) begin
            foreach (wr_m[i]) begin wr_m[i] = 0; ld_m[i] = 0; end
            return;
        end
        foreach (net_w[i]) begin net_w[i] = 0; net_l[i] = 0; end
        if (iss0_valid) begin net_w[iss0_rd]++; if (iss0_is_load) net_l[iss0_rd]++; end
        if (iss1_valid) begin net_w[iss1_rd]++; if (iss1_is_load) net_l[iss1_rd]++; end
        if (wb0_valid)  begin net_w[wb0_rd]--;  if (wb0_is_load)  net_l[wb0_rd]--;  end
        if (wb1_valid)  begin net_w[wb1_rd]--;  if (wb1_is_load)  net_l[wb1_rd]--;  end
        for (int i = 1; i < 32; i++) begin
            wr_m[i] = clipCount(wr_m[i] + net_w[i], ovf_m, unf_m);
            ld_m[i] = clipCount(ld_m[i] + net_l[i], ovf_m, unf_m);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the model's prediction.
    task automatic checkOutput(input string tag);
        logic [31:0] busy_e, ld_e;
        busy_e = '0;
        ld_e   = '0;
        for (int i = 1; i < 32; i++) begin
            busy_e[i] = (wr_m[i] != 0);
            ld_e[i]   = (ld_m[i] != 0);
        end
        checkVal({tag, ".busy"}, busy_vec, busy_e);
        checkVal({tag, ".ldpend"}, load_pending_vec, ld_e);
        checkVal({tag, ".ovf"}, {31'd0, overflow_err}, {31'd0, ovf_m});
        checkVal({tag, ".unf"}, {31'd0, underflow_err}, {31'd0, unf_m});
    endtask

    // Clocks the currently driven inputs in, updates the model, returns to idle
    // and lets outputs settle before the caller checks.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        setIdle();
    endtask

    initial begin
        setIdle();
        foreach (wr_m[i]) begin wr_m[i] = 0; ld_m[i] = 0; end
        ovf_m = 1'b0;
        unf_m = 1'b0;
        #2;

        // Reset state
        rst = 1'b1;
        applyStimulus();
        checkOutput("reset");
        checkVal("reset.busy_const", busy_vec, 32'h0);

        // Basic issue / retire
        doIssue(0, 5, 1'b0);
        applyStimulus();
        checkOutput("basic_issue");
        checkVal("basic_issue.busy_const", busy_vec, 32'h20);
        checkVal("basic_issue.ld_const", load_pending_vec, 32'h0);
        doWb(0, 5, 1'b0);
        applyStimulus();
        checkVal("basic_wb.busy_const", busy_vec, 32'h0);

        // Load tracking with a simultaneous x0 issue
        doIssue(1, 7, 1'b1);
        doIssue(0, 0, 1'b0);
        applyStimulus();
        checkOutput("load_issue");
        checkVal("load_issue.busy_const", busy_vec, 32'h80);
        checkVal("load_issue.ld_const", load_pending_vec, 32'h80);
        doWb(1, 7, 1'b1);
        applyStimulus();
        checkVal("load_wb.busy_const", busy_vec, 32'h0);
        checkVal("load_wb.ld_const", load_pending_vec, 32'h0);
        checkVal("load_wb.unf_const", {31'd0, underflow_err}, 32'h0);

        // Simultaneous events: wr_cnt[3] 1 -> 1+2-1 = 2, wb to idle r9 underflows
        doIssue(0, 3, 1'b0);
        applyStimulus();
        doIssue(0, 3, 1'b0);
        doIssue(1, 3, 1'b0);
        doWb(0, 3, 1'b0);
        doWb(1, 9, 1'b0);
        applyStimulus();
        checkOutput("simul");
        checkVal("simul.busy_const", busy_vec, 32'h8);
        checkVal("simul.unf_const", {31'd0, underflow_err}, 32'h1);
        // Two retirements must be needed to free r3 (count was 2)
        doWb(0, 3, 1'b0);
        applyStimulus();
        checkVal("simul.r3_still_busy", busy_vec, 32'h8);
        doWb(0, 3, 1'b0);
        applyStimulus();
        checkVal("simul.r3_free", busy_vec, 32'h0);

        // Saturation: four issues hold at 3, three wbs clear it
        for (int k = 0; k < 4; k++) begin
            doIssue(0, 12, 1'b0);
            applyStimulus();
        end
        checkOutput("sat_issue");
        checkVal("sat_issue.ovf_const", {31'd0, overflow_err}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            doWb(0, 12, 1'b0);
            applyStimulus();
        end
        checkVal("sat_wb2.busy_const", busy_vec, 32'h1000);
        doWb(0, 12, 1'b0);
        applyStimulus();
        checkOutput("sat_wb3");
        checkVal("sat_wb3.busy_const", busy_vec, 32'h0);

        // Flush beats issue, flags untouched
        doIssue(0, 1, 1'b1);
        doIssue(1, 2, 1'b0);
        applyStimulus();
        doIssue(0, 4, 1'b0);
        applyStimulus();
        checkVal("pre_flush.busy_const", busy_vec, 32'h16);
        flush = 1'b1;
        doIssue(0, 6, 1'b1);
        applyStimulus();
        checkOutput("flush");
        checkVal("flush.busy_const", busy_vec, 32'h0);
        checkVal("flush.ld_const", load_pending_vec, 32'h0);
        checkVal("flush.flags_const", {30'd0, overflow_err, underflow_err}, 32'h3);

        // Reset mid-operation with 0xF0F0 busy
        for (int k = 0; k < 4; k++) begin
            doIssue(0, 4 + k, 1'b0);
            doIssue(1, 12 + k, 1'b1);
            applyStimulus();
        end
        checkVal("pre_rst.busy_const", busy_vec, 32'h0000_F0F0);
        rst = 1'b1;
        doWb(0, 4, 1'b0);
        doWb(1, 12, 1'b1);
        applyStimulus();
        checkOutput("mid_reset");
        checkVal("mid_reset.all_const",
                 busy_vec | load_pending_vec | {30'd0, overflow_err, underflow_err},
                 32'h0);

        // Randomized traffic, mostly on a few registers to force interaction
        for (int n = 0; n < 400; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
            if ($urandom_range(0, 1) == 1) doIssue(0, $urandom_range(0, hi), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) doIssue(1, $urandom_range(0, hi), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) doWb(0, $urandom_range(0, hi), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) doWb(1, $urandom_range(0, hi), 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            applyStimulus();
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for the dual-issue pipeline. It tracks in-flight register writers from issue until writeback and produces the `busy_vec` / `load_pending_vec` views that the issue logic reads. Per-register outstanding-writer and outstanding-load counters are incremented by the two issue slots and decremented by the two writeback ports. It sits between the ID/issue stage (producer side) and the WB stage (consumer side).

## Interface
- `CNT_W`, default 2: width of each per-register counter. Maximum outstanding writers per register is 2^CNT_W−1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: pipeline flush; discards all in-flight tracking.
- `iss0_valid` input 1: slot0 issued a register writer this cycle.
- `iss0_rd` input 5: slot0 destination.
- `iss0_is_load` input 1: slot0 writer is a load.
- `iss1_valid`, `iss1_rd`, `iss1_is_load`: same as slot0, for slot1.
- `wb0_valid` input 1: writeback port 0 retires a writer this cycle.
- `wb0_rd` input 5: retiring destination.
- `wb0_is_load` input 1: retiring writer was a load.
- `wb1_valid`, `wb1_rd`, `wb1_is_load`: same as port 0, for port 1.
- `busy_vec` output 32: bit i = 1 iff `wr_cnt[i]` != 0.
- `load_pending_vec` output 32: bit i = 1 iff `ld_cnt[i]` != 0.
- `overflow_err` output 1: sticky; a counter saturated.
- `underflow_err` output 1: sticky; a decrement found a zero counter.

## Operation
- State: `wr_cnt[1..31]` and `ld_cnt[1..31]`, each CNT_W bits. Register 0 has no state.
- `busy_vec[0]` and `load_pending_vec[0]` are constant 0.
- Any event with rd == 0 is ignored. This applies to both issue and writeback.
- Per-register net update each cycle:
  - inc_w = number of valid issue slots with rd == i (0..2).
  - dec_w = number of valid wb ports with rd == i (0..2).
  - inc_l / dec_l count the same events, restricted to those with `is_load` = 1.
  - next = cur + inc − dec, computed at CNT_W+2 bits signed.
- Same-cycle issue and writeback to the same register net out. Example: cur 1, one issue, one wb → stays 1; busy stays high.
- Both slots issuing the same rd in one cycle adds 2. The issue logic normally prevents this for slot1, but the scoreboard must still support it.
- Saturation: if next > 2^CNT_W−1, the counter holds at the max value and `overflow_err` sets.
- Underflow: if next < 0, the counter becomes 0 and `underflow_err` sets.
- `ld_cnt` follows the same saturation and underflow rules and feeds the same error flags.
- A wb with `is_load` = 1 on a register whose `ld_cnt` is 0 is an underflow.
- `flush` = 1: all counters go to 0 on the next edge.
  - Issue and wb events in the flush cycle are ignored.
  - Error flags are not changed by flush.
- Error flags clear only on `rst`.

## Timing
- Outputs are decoded combinationally from registered counters, with no input-to-output path.
- An issue at edge N is visible on `busy_vec` immediately after edge N. The issue logic therefore sees it on the next decode cycle.
- A writeback at edge N clears busy (when the count reaches 0) after edge N. There is no same-cycle bypass; forwarding covers that cycle.
- Reset values: all counters 0, `busy_vec` = 0, `load_pending_vec` = 0, `overflow_err` = 0, `underflow_err` = 0.
- Priority when asserted in the same cycle: `rst` > `flush` > issue/wb update.
- Reset asserted mid-operation discards all in-flight state on that edge.
- Errors set on the edge where the offending update occurs. They are visible the following cycle.

## Test plan
- **Basic issue/retire.**
  - Reset, then issue slot0 rd=5, non-load → next cycle `busy_vec` = 0x20 and `load_pending_vec` = 0.
  - Then wb0 rd=5 → `busy_vec` = 0.
- **Load tracking and x0.**
  - Slot1 issue rd=7 with `is_load` = 1, plus slot0 issue rd=0 → `busy_vec` = 0x80 and `load_pending_vec` = 0x80.
  - Wb1 rd=7 with `is_load` = 1 → both vectors 0.
- **Simultaneous events.**
  - Starting from `wr_cnt[3]` = 1, in one cycle: issue slot0 rd=3, issue slot1 rd=3, wb0 rd=3, wb1 rd=9.
  - Required: `wr_cnt[3]` = 2; bit 3 busy.
  - Bit 9 was 0 before, so `underflow_err` = 1.
- **Saturation** (CNT_W=2).
  - Four issues to rd=12 across cycles with no wb → counter holds 3 and `overflow_err` = 1.
  - Three wb to rd=12 → busy bit 12 clears.
- **Flush priority.**
  - With rd 1, 2, 4 busy: assert `flush` together with issue rd=6 → next cycle `busy_vec` = 0 and `load_pending_vec` = 0.
  - Error flags unchanged.
- **Reset mid-operation.**
  - With `busy_vec` = 0x0000_F0F0, `overflow_err` = 1, assert `rst` together with wb events → all outputs 0 next cycle.
